seq_mul_acc: RTL and testbench

- Multi-cycle shift-and-add multiply-accumulate: Product = Quotient * Divisor + Remainder.
- Inverse of the combinational divider. Rebuilds the dividend from the divider's quotient, divisor and remainder.
- Used as an in-system checker behind the divider and as a standalone multiplier.
- Start/Busy/Done handshake; one clock domain.

---
 rtl/seq_mul_acc.sv | 82 ++++++++
 tb/tb_seq_mul_acc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_acc.sv
// Multi-cycle shift-and-add multiply-accumulate: Product = Quotient * Divisor + Remainder.
// Optional macro SEQ_MUL_ACC_EARLY_EXIT_EN ends RUN as soon as the remaining multiplier bits are zero.
module seq_mul_acc #(
   parameter int Q_W = 4,
   parameter int D_W = 2,
   parameter int R_W = 3,
   parameter int P_W = Q_W + D_W + 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           Start,
   input  logic [Q_W-1:0] Quotient,
   input  logic [D_W-1:0] Divisor,
   input  logic [R_W-1:0] Remainder,
   output logic           Busy,
   output logic           Done,
   output logic [P_W-1:0] Product
);

   localparam int CW = (D_W > 1) ? $clog2(D_W) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_next;
   logic [P_W-1:0] acc, mcand, acc_sum;
   logic [D_W-1:0] mplier;
   logic [CW-1:0]  count;
   logic           last_iter;

   // One iteration's partial sum; the final iteration's sum is the result.
   always_comb begin
      acc_sum = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MUL_ACC_EARLY_EXIT_EN
      last_iter = (count == CW'(D_W - 1)) || ((mplier >> 1) == '0);
`else
      last_iter = (count == CW'(D_W - 1));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = RUN;
         RUN:     if (last_iter) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign Busy = (state != IDLE);
   assign Done = (state == DONE);

   // Operands are captured only in IDLE, so later input changes never disturb a running operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         Product <= '0;
      end else if (state == IDLE) begin
         if (Start) begin
            acc    <= P_W'(Remainder);
            mcand  <= P_W'(Quotient);
            mplier <= Divisor;
            count  <= '0;
         end
      end else if (state == RUN) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (last_iter) Product <= acc_sum;
      end
   end

endmodule

// File: tb/tb_seq_mul_acc.sv
// Directed self-checking bench for seq_mul_acc (default parameters, with or without SEQ_MUL_ACC_EARLY_EXIT_EN).
module tb_seq_mul_acc;

   logic       clk;
   logic       rst_n;
   logic       Start;
   logic [3:0] Quotient;
   logic [1:0] Divisor;
   logic [2:0] Remainder;
   logic       Busy;
   logic       Done;
   logic [6:0] Product;

   int compared;
   int mismatched;

   seq_mul_acc dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .Start    (Start),
      .Quotient (Quotient),
      .Divisor  (Divisor),
      .Remainder(Remainder),
      .Busy     (Busy),
      .Done     (Done),
      .Product  (Product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected RUN length: fixed D_W, or the multiplier's bit length (at least 1) with early exit.
   function automatic int exp_runs(input logic [1:0] d);
`ifdef SEQ_MUL_ACC_EARLY_EXIT_EN
      return d[1] ? 2 : 1;
`else
      return 2;
`endif
   endfunction

   // Issues one operation and measures it; scrambles operands after acceptance.
   task automatic run_op(input logic [3:0] q, input logic [1:0] d, input logic [2:0] r,
                         output int lat, output int busyCycles, output int doneCycles,
                         output logic [6:0] prod);
      @(negedge clk);
      Start = 1'b1; Quotient = q; Divisor = d; Remainder = r;
      @(posedge clk); #1;
      Start = 1'b0;
      Quotient = 4'($urandom); Divisor = 2'($urandom); Remainder = 3'($urandom);
      lat = -1; doneCycles = 0; prod = 'x;
      busyCycles = Busy ? 1 : 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (Busy) busyCycles++;
         if (Done) begin
            doneCycles++;
            if (lat < 0) begin
               lat = n;
               prod = Product;
            end
         end
         if (!Busy) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; Start = 1'b0; Quotient = '0; Divisor = '0; Remainder = '0;
      repeat (2) @(posedge clk);
      #1;
      compared++;
      if (Busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", Busy); end
      compared++;
      if (Done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", Done); end
      compared++;
      if (Product !== 7'd0) begin mismatched++; $display("[TB] FAIL reset_product: got %0d expected 0", Product); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat, busyCycles, doneCycles;
      logic [6:0] prod;
      run_op(4'd4, 2'd2, 3'd0, lat, busyCycles, doneCycles, prod);
      compared++;
      if (prod !== 7'd8) begin mismatched++; $display("[TB] FAIL basic_product: got %0d expected 8", prod); end
      compared++;
      if (lat != exp_runs(2'd2)) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, exp_runs(2'd2)); end
      compared++;
      if (doneCycles != 1) begin mismatched++; $display("[TB] FAIL basic_done_width: got %0d expected 1", doneCycles); end
      compared++;
      if (busyCycles != exp_runs(2'd2) + 1) begin mismatched++; $display("[TB] FAIL basic_busy_cycles: got %0d expected %0d", busyCycles, exp_runs(2'd2) + 1); end
      compared++;
      if (Product !== 7'd8) begin mismatched++; $display("[TB] FAIL basic_product_held: got %0d expected 8", Product); end
   endtask

   task automatic test_sequential();
      logic [3:0] qs [5] = '{4'd5, 4'd3, 4'd3, 4'd6, 4'd15};
      logic [1:0] ds [5] = '{2'd3, 2'd2, 2'd3, 2'd1, 2'd3};
      logic [2:0] rs [5] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd7};
      logic [6:0] ps [5] = '{7'd15, 7'd7, 7'd9, 7'd6, 7'd52};
      int lat, busyCycles, doneCycles;
      logic [6:0] prod;
      for (int i = 0; i < 5; i++) begin
         run_op(qs[i], ds[i], rs[i], lat, busyCycles, doneCycles, prod);
         compared++;
         if (prod !== ps[i]) begin mismatched++; $display("[TB] FAIL seq_product[%0d]: got %0d expected %0d", i, prod, ps[i]); end
         compared++;
         if (lat != exp_runs(ds[i])) begin mismatched++; $display("[TB] FAIL seq_latency[%0d]: got %0d expected %0d", i, lat, exp_runs(ds[i])); end
      end
   endtask

   task automatic test_divisor_zero();
      int lat, busyCycles, doneCycles;
      logic [6:0] prod;
      run_op(4'd15, 2'd0, 3'd7, lat, busyCycles, doneCycles, prod);
      compared++;
      if (prod !== 7'd7) begin mismatched++; $display("[TB] FAIL div0_product: got %0d expected 7", prod); end
      compared++;
      if (lat != exp_runs(2'd0)) begin mismatched++; $display("[TB] FAIL div0_latency: got %0d expected %0d", lat, exp_runs(2'd0)); end
      compared++;
      if (busyCycles != exp_runs(2'd0) + 1) begin mismatched++; $display("[TB] FAIL div0_busy_cycles: got %0d expected %0d", busyCycles, exp_runs(2'd0) + 1); end
   endtask

   task automatic test_back_to_back();
      logic       busyLog [21];
      logic       doneLog [21];
      logic [6:0] prodLog [21];
      int d1, idle, d2;
      d1   = exp_runs(2'd3);
      idle = d1 + 1;
      d2   = idle + 1 + exp_runs(2'd2);
      @(negedge clk);
      Start = 1'b1; Quotient = 4'd5; Divisor = 2'd3; Remainder = 3'd0;
      @(posedge clk); #1;
      busyLog[0] = Busy; doneLog[0] = Done; prodLog[0] = Product;
      Quotient = 4'd3; Divisor = 2'd2; Remainder = 3'd1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         busyLog[n] = Busy; doneLog[n] = Done; prodLog[n] = Product;
      end
      Start = 1'b0;
      for (int n = 0; n < 20 && Busy; n++) @(posedge clk) #1;
      compared++;
      if (doneLog[d1] !== 1'b1 || prodLog[d1] !== 7'd15) begin
         mismatched++; $display("[TB] FAIL b2b_first: done=%b product=%0d expected done=1 product=15", doneLog[d1], prodLog[d1]);
      end
      compared++;
      if (doneLog[d1 - 1] !== 1'b0 || doneLog[idle] !== 1'b0) begin
         mismatched++; $display("[TB] FAIL b2b_done_pulse: before=%b after=%b expected 0 and 0", doneLog[d1 - 1], doneLog[idle]);
      end
      compared++;
      if (busyLog[idle] !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_gap: busy=%b expected 0", busyLog[idle]); end
      compared++;
      if (busyLog[idle + 1] !== 1'b1 || prodLog[idle + 1] !== 7'd15) begin
         mismatched++; $display("[TB] FAIL b2b_second_run: busy=%b product=%0d expected busy=1 product=15", busyLog[idle + 1], prodLog[idle + 1]);
      end
      compared++;
      if (doneLog[d2] !== 1'b1 || prodLog[d2] !== 7'd7) begin
         mismatched++; $display("[TB] FAIL b2b_second: done=%b product=%0d expected done=1 product=7", doneLog[d2], prodLog[d2]);
      end
   endtask

   task automatic test_reset_mid();
      int lat, busyCycles, doneCycles;
      logic [6:0] prod;
      int sawDone;
      @(negedge clk);
      Start = 1'b1; Quotient = 4'd15; Divisor = 2'd3; Remainder = 3'd7;
      @(posedge clk); #1;
      Start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      compared++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 7'd0) begin
         mismatched++; $display("[TB] FAIL midreset_outputs: busy=%b done=%b product=%0d expected 0 0 0", Busy, Done, Product);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sawDone = 0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (Done || Busy) sawDone++;
      end
      compared++;
      if (sawDone != 0) begin mismatched++; $display("[TB] FAIL midreset_no_done: active cycles=%0d expected 0", sawDone); end
      run_op(4'd6, 2'd1, 3'd0, lat, busyCycles, doneCycles, prod);
      compared++;
      if (prod !== 7'd6 || lat != exp_runs(2'd1)) begin
         mismatched++; $display("[TB] FAIL midreset_next_op: product=%0d latency=%0d expected 6 and %0d", prod, lat, exp_runs(2'd1));
      end
   endtask

   task automatic test_sweep();
      int lat, busyCycles, doneCycles;
      logic [6:0] prod;
      logic [6:0] expected;
      for (int q = 0; q < 16; q++) begin
         for (int d = 0; d < 4; d++) begin
            for (int r = 0; r < 8; r++) begin
               expected = 7'(q * d + r);
               run_op(4'(q), 2'(d), 3'(r), lat, busyCycles, doneCycles, prod);
               compared++;
               if (prod !== expected || lat != exp_runs(2'(d))) begin
                  mismatched++;
                  $display("[TB] FAIL sweep q=%0d d=%0d r=%0d: product=%0d latency=%0d expected %0d and %0d",
                           q, d, r, prod, lat, expected, exp_runs(2'(d)));
               end
            end
         end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      test_reset();
      test_basic();
      test_sequential();
      test_divisor_zero();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
